// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM responder: command codes, mode fields, err bits.
// No logic beyond a burst-length decode helper.
// No flow control; everything here is static.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD_MODE    = 3'b000,
    CMD_AUTO_REFRESH = 3'b001,
    CMD_PRECHARGE    = 3'b010,
    CMD_ACTIVE       = 3'b011,
    CMD_WRITE        = 3'b100,
    CMD_READ         = 3'b101,
    CMD_BURST_TERM   = 3'b110,
    CMD_NOP          = 3'b111
  } sd_cmd_e;

  localparam int MR_BL_LSB = 0;
  localparam int MR_BL_MSB = 2;
  localparam int MR_BT     = 3;
  localparam int MR_CL_LSB = 4;
  localparam int MR_CL_MSB = 6;
  localparam int MR_WB     = 9;
  localparam int ADDR_AP   = 10;

  localparam int ERR_W          = 6;
  localparam int ERR_ACT_ACTIVE = 0;
  localparam int ERR_RW_IDLE    = 1;
  localparam int ERR_TRCD       = 2;
  localparam int ERR_BUSY_BANK  = 3;
  localparam int ERR_NO_MODE    = 4;
  localparam int ERR_BAD_MODE   = 5;

  localparam logic [1:0] TRCD = 2'd2;

  typedef struct packed {
    logic        active;
    logic [12:0] row;
    logic [1:0]  trcd;
  } bank_t;

  function automatic logic [3:0] burst_len(input logic [12:0] mr);
    case (mr[MR_BL_MSB:MR_BL_LSB])
      3'b001:  return 4'd2;
      3'b010:  return 4'd4;
      3'b011:  return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// One SDRAM bank: idle/active state, open row and tRCD countdown.
// State updates on the command edge, visible from the next cycle.
// No backpressure; commands are accepted every cycle.
module sdram_resp_bank
  import sdram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        act,
  input  logic [12:0] row,
  input  logic        idle,
  output bank_t       st
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= '0;
    end else begin
      if (st.trcd != 2'd0)
        st.trcd <= st.trcd - 2'd1;
      if (act) begin
        st.active <= 1'b1;
        st.row    <= row;
        st.trcd   <= TRCD;
      end else if (idle) begin
        st.active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM chip model: command decode, bursts and block-RAM storage; checker under SDRAM_RESP_CHECK_EN.
// Read beat k appears in the cycle ending at edge n+CL+k; write beat k is sampled at edge n+k.
// No backpressure; the bus master owns all timing.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int MEM_AW = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_ba,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_data_in,
  output logic [15:0] sd_data_out,
  output logic        sd_data_oe,
  output logic [12:0] mode_reg,
  output logic        mode_valid,
  output logic [15:0] refresh_cnt,
  output logic [5:0]  err
);

  localparam int RW = MEM_AW - 11;

  sd_cmd_e cmd;
  logic is_act, is_rd, is_wr, is_rw, is_term, is_pre, is_ref, is_lmr;

  assign cmd     = sd_cs ? CMD_NOP : sd_cmd_e'({sd_ras, sd_cas, sd_we});
  assign is_act  = (cmd == CMD_ACTIVE);
  assign is_rd   = (cmd == CMD_READ);
  assign is_wr   = (cmd == CMD_WRITE);
  assign is_rw   = is_rd || is_wr;
  assign is_term = (cmd == CMD_BURST_TERM);
  assign is_pre  = (cmd == CMD_PRECHARGE);
  assign is_ref  = (cmd == CMD_AUTO_REFRESH);
  assign is_lmr  = (cmd == CMD_LOAD_MODE);

  bank_t      bank_st [4];
  bank_t      sel;
  logic [3:0] bank_act, bank_idle;
  logic       rw_go;
  logic       unused_bank_bits;

  assign sel              = bank_st[sd_ba];
  assign rw_go            = is_rw && sel.active;
  assign unused_bank_bits = ^{bank_st[0], bank_st[1], bank_st[2], bank_st[3]};

  // Burst in flight; beat 0 is always issued straight from the command.
  logic          bst_vld, bst_wr, bst_ap;
  logic [1:0]    bst_ba;
  logic [RW-1:0] bst_row;
  logic [8:0]    bst_start;
  logic [2:0]    bst_k;
  logic [3:0]    bst_len;

  logic          beat_vld, beat_wr, beat_ap, beat_last;
  logic [1:0]    beat_ba;
  logic [RW-1:0] beat_row;
  logic [8:0]    beat_start, beat_col;
  logic [2:0]    beat_k, beat_m;
  logic [3:0]    beat_len;
  logic [MEM_AW-1:0] beat_addr;

  always_comb begin
    beat_vld   = bst_vld;
    beat_wr    = bst_wr;
    beat_ap    = bst_ap;
    beat_ba    = bst_ba;
    beat_row   = bst_row;
    beat_start = bst_start;
    beat_k     = bst_k;
    beat_len   = bst_len;
    if (rw_go) begin
      beat_vld   = 1'b1;
      beat_wr    = is_wr;
      beat_ap    = sd_addr[ADDR_AP];
      beat_ba    = sd_ba;
      beat_row   = sel.row[RW-1:0];
      beat_start = sd_addr[8:0];
      beat_k     = 3'd0;
      beat_len   = (is_wr && mode_reg[MR_WB]) ? 4'd1 : burst_len(mode_reg);
    end
  end

  // Burst length is a power of two, so the wrap only touches the low 3 column bits.
  assign beat_m    = 3'(beat_len - 4'd1);
  assign beat_col  = {beat_start[8:3],
                      (beat_start[2:0] & ~beat_m) | ((beat_start[2:0] + beat_k) & beat_m)};
  assign beat_last = ({1'b0, beat_k} == (beat_len - 4'd1));
  assign beat_addr = {beat_ba, beat_row, beat_col};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bst_vld   <= 1'b0;
      bst_wr    <= 1'b0;
      bst_ap    <= 1'b0;
      bst_ba    <= '0;
      bst_row   <= '0;
      bst_start <= '0;
      bst_k     <= '0;
      bst_len   <= 4'd1;
    end else begin
      bst_vld   <= beat_vld && !beat_last && !is_term;
      bst_wr    <= beat_wr;
      bst_ap    <= beat_ap;
      bst_ba    <= beat_ba;
      bst_row   <= beat_row;
      bst_start <= beat_start;
      bst_k     <= beat_k + 3'd1;
      bst_len   <= beat_len;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    assign bank_act[b]  = is_act && (sd_ba == 2'(b));
    assign bank_idle[b] = (is_pre && (sd_addr[ADDR_AP] || sd_ba == 2'(b))) ||
                          (beat_vld && beat_last && beat_ap && beat_ba == 2'(b));
    sdram_resp_bank u_bank (
      .clk   (clk),
      .reset (reset),
      .act   (bank_act[b]),
      .row   (sd_addr),
      .idle  (bank_idle[b]),
      .st    (bank_st[b])
    );
  end

  // Storage is never reset so contents survive a controller reset.
  logic [15:0] mem [0:(1<<MEM_AW)-1];
  logic [15:0] rd_dat;

  always_ff @(posedge clk) begin
    if (beat_vld && beat_wr) begin
      if (!sd_dqm[0]) mem[beat_addr][7:0]  <= sd_data_in[7:0];
      if (!sd_dqm[1]) mem[beat_addr][15:8] <= sd_data_in[15:8];
    end
    rd_dat <= mem[beat_addr];
  end

  logic        p0_vld, p1_vld, p2_vld, cl3;
  logic [15:0] p1_dat, p2_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_vld <= 1'b0;
      p1_vld <= 1'b0;
      p2_vld <= 1'b0;
      p1_dat <= '0;
      p2_dat <= '0;
    end else begin
      p0_vld <= beat_vld && !beat_wr;
      p1_vld <= p0_vld;
      p1_dat <= p0_vld ? rd_dat : '0;
      p2_vld <= p1_vld;
      p2_dat <= p1_dat;
    end
  end

  assign cl3         = (mode_reg[MR_CL_MSB:MR_CL_LSB] == 3'd3);
  assign sd_data_oe  = cl3 ? p2_vld : p1_vld;
  assign sd_data_out = cl3 ? p2_dat : p1_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg    <= '0;
      mode_valid  <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      if (is_lmr) begin
        mode_reg   <= sd_addr;
        mode_valid <= 1'b1;
      end
      if (is_ref)
        refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

`ifdef SDRAM_RESP_CHECK_EN
  logic [ERR_W-1:0] err_set;
  logic             any_active;

  assign any_active = bank_st[0].active || bank_st[1].active ||
                      bank_st[2].active || bank_st[3].active;

  always_comb begin
    err_set                 = '0;
    err_set[ERR_ACT_ACTIVE] = is_act && sel.active;
    err_set[ERR_RW_IDLE]    = is_rw && !sel.active;
    // Counter loads at the ACTIVE edge, so above 1 means tRCD has not yet elapsed.
    err_set[ERR_TRCD]       = rw_go && (sel.trcd > 2'd1);
    err_set[ERR_BUSY_BANK]  = (is_lmr || is_ref) && any_active;
    err_set[ERR_NO_MODE]    = is_rw && !mode_valid;
    err_set[ERR_BAD_MODE]   = is_lmr && (sd_addr[MR_BT] ||
                              !(sd_addr[MR_CL_MSB:MR_CL_LSB] == 3'd2 ||
                                sd_addr[MR_CL_MSB:MR_CL_LSB] == 3'd3));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= '0;
    else       err <= err | err_set;
  end
`else
  assign err = '0;
`endif

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable SDR SDRAM device responder: the chip side of the 16-bit SDRAM command bus our 64 MHz controller drives. It decodes RAS/CAS/WE/CS commands, tracks per-bank row state and the mode register, and serves reads and writes from an internal block-RAM array with CAS-latency-accurate data timing. It replaces the external chip in simulation and FPGA loopback tests, and can optionally flag protocol violations.

## Interface
- MEM_AW, 16: word-address width of the internal array, `{ba[1:0], row[MEM_AW-12:0], col[8:0]}`. Minimum 12.
- clk  in  1  command clock; all command pins are sampled on its rising edge.
- reset  in  1  asynchronous, active-high.
- sd_addr  in  13  multiplexed address. Column = `{A8, A7:A0}`; A10 = auto-precharge / precharge-all.
- sd_ba  in  2  bank select.
- sd_cs, sd_ras, sd_cas, sd_we  in  1 each  active-low command pins.
- sd_dqm  in  2  byte masks for writes. Bit1 masks the high byte; 1 = masked.
- sd_data_in  in  16  write data from the bus.
- sd_data_out  out  16  read data. Reset value 0.
- sd_data_oe  out  1  drive enable for the external tristate. Reset value 0.
- mode_reg  out  13  last loaded mode register. Reset value 0.
- mode_valid  out  1  set by the first LOAD_MODE. Reset value 0.
- refresh_cnt  out  16  AUTO_REFRESH count; wraps at 0xFFFF. Reset value 0.
- err  out  6  sticky violation flags. Reset value 0. Always 0 without the macro.

## Operation
- A command is decoded only when sd_cs=0. Encoding `{ras,cas,we}`:
  - 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE
  - 110 BURST_TERMINATE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE
- Bank state: 4 banks, each IDLE or ACTIVE(row) plus a tRCD counter.
  - ACTIVE: bank → ACTIVE with the row latched; counter = 2.
  - ACTIVE to an already-ACTIVE bank replaces the row.
- LOAD_MODE:
  - mode_reg ← sd_addr; mode_valid ← 1.
  - Fields: BL [2:0] (000/001/010/011 = 1/2/4/8), CL [6:4] (2 or 3; any other value is treated as 2), write-single [9].
  - Before the first LOAD_MODE: CL=2, BL=1.
- READ/WRITE to an ACTIVE bank:
  - Start column from sd_addr.
  - Beat k uses column `(col & ~(BL-1)) | ((col+k) & (BL-1))` (sequential wrap within the burst).
  - With A10=1, the bank goes IDLE after the last beat.
  - Write bursts use length BL, or length 1 when mode bit 9 = 1.
- READ/WRITE to an IDLE bank is ignored: no data driven, no memory change.
- Write beats: sd_dqm applies per beat; a masked byte is not written.
- New READ/WRITE during a burst: the current burst stops issuing beats. Read beats already in the CL pipeline still complete.
- BURST_TERMINATE: no further beats are issued after this edge.
- PRECHARGE: A10=1 idles all banks; A10=0 idles bank sd_ba.
- AUTO_REFRESH: refresh_cnt increments; bank state is unchanged.
- Reset: clears bank state, burst, read pipeline, outputs and mode. Memory contents are retained.

## Timing
- Edge n is the edge at which the command is sampled.
- Read: beat k is driven on sd_data_out with sd_data_oe=1 for exactly the one cycle ending at edge n+CL+k.
  - sd_data_oe is low in all other cycles.
  - Back-to-back reads give continuous oe.
- Write: beat k data and dqm are sampled at edge n+k. A read of the same address issued at edge n+1 returns the new data.
- tRCD: a READ/WRITE at edge m+2 or later after ACTIVE at edge m is legal. An earlier one is executed normally and flagged.
- Auto-precharge: the bank is IDLE from the edge after the last beat's sample edge. A read's last sample edge is n+BL-1.
- Asynchronous reset: sd_data_oe drops immediately, without waiting for a clock edge.

## Configuration
- SDRAM_RESP_CHECK_EN defined: protocol checker is compiled in. err bits set sticky, cleared only by reset:
  - [0] ACTIVE to an ACTIVE bank
  - [1] READ/WRITE to an IDLE bank
  - [2] tRCD violation
  - [3] LOAD_MODE or AUTO_REFRESH with any bank ACTIVE
  - [4] READ/WRITE before mode_valid
  - [5] LOAD_MODE with CL not 2/3, or with the interleaved bit set
- Undefined: err tied to 0 and the checker logic is absent. Functional behaviour is identical in both builds.

## Structure
- sdram_pkg holds:
  - command encodings
  - mode-register field positions
  - err bit indices
  - bank-state typedef (active, row, trcd count)
- Sub-module sdram_resp_bank: per-bank state and tRCD counter, instantiated 4 times.
- The memory array, burst sequencer and read CL pipeline stay in the top module.

## Test plan
- Reset, then LOAD_MODE sd_addr=0x220 → mode_valid=1, mode_reg=0x220, CL=2, BL=1.
- ACTIVE b1 row 5; WRITE col 0x10 0xA55A dqm=00 A10=1 at +2; ACTIVE; READ at +2 → oe=1 only in the cycle ending at edge n+2, data 0xA55A; bank 1 IDLE afterwards.
- Masked write: WRITE 0x1234 dqm=01 over 0xA55A → read returns 0x125A.
- LOAD_MODE 0x032 (CL3, BL4); READ col 6 → beats from cols 6, 7, 4, 5 at edges n+3..n+6, oe continuous for 4 cycles.
- With SDRAM_RESP_CHECK_EN: READ to an IDLE bank → err[1]=1, oe stays 0; READ one cycle after ACTIVE → err[2]=1, data still returned.
- Assert reset mid-burst → oe=0 immediately, mode_valid=0, err=0; after re-init, previously written data still reads back.
